// File: rtl/step_receiver.sv
// step_receiver: six-axis step/direction receiver.
// Synchronises the PU/DR/MF/Stop pulse interface, tracks absolute position
// per axis (0..POS_MAX), frames step bursts into moves, and reads back the
// selected axis position as three BCD digits plus its last move length.
module step_receiver #(
    parameter int NAXIS    = 6,
    parameter int IDLE_CYC = 200,
    parameter int POS_MAX  = 999
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic [NAXIS-1:0] PU,
    input  logic [NAXIS-1:0] DR,
    input  logic [NAXIS-1:0] MF,
    input  logic [NAXIS-1:0] Stop,
    input  logic [2:0]       Sel,
    output logic [3:0]       PosValue0,
    output logic [3:0]       PosValue1,
    output logic [3:0]       PosValue2,
    output logic [9:0]       LastSteps,
    output logic [NAXIS-1:0] Moving,
    output logic [NAXIS-1:0] Done,
    output logic [NAXIS-1:0] Homed,
    output logic [NAXIS-1:0] Fault
);

    localparam int              TIMER_W   = $clog2(IDLE_CYC);
    localparam logic [TIMER_W-1:0] IDLE_LAST = TIMER_W'(IDLE_CYC - 1);
    localparam logic [9:0]      POS_TOP   = 10'(POS_MAX);
    localparam logic [9:0]      CNT_TOP   = 10'h3FF;

    // Moving mirrors the state register, so the move FSM state is visible
    // on the Moving output without an extra debug port.
    typedef enum logic {ST_IDLE = 1'b0, ST_MOVING = 1'b1} state_t;

    logic [NAXIS-1:0] pu_s1, pu_s2, pu_s3;
    logic [NAXIS-1:0] dr_s1, dr_s2;
    logic [NAXIS-1:0] mf_s1, mf_s2;
    logic [NAXIS-1:0] stop_s1, stop_s2;

    logic [NAXIS-1:0] step_evt;
    logic [NAXIS-1:0] accept;

    logic [9:0]         pos        [NAXIS];
    logic [9:0]         count      [NAXIS];
    logic [9:0]         last_steps [NAXIS];
    logic [TIMER_W-1:0] timer      [NAXIS];
    state_t             state      [NAXIS];

    logic [9:0]  sel_pos;
    logic [9:0]  sel_last;
    logic [11:0] sel_bcd;

    // Double dabble: 10-bit binary to three BCD digits (input never exceeds 999).
    function automatic logic [11:0] bin2bcd(input logic [9:0] bin);
        logic [21:0] sh;
        sh = {12'd0, bin};
        for (int k = 0; k < 10; k++) begin
            for (int d = 0; d < 3; d++) begin
                if (sh[10+4*d +: 4] > 4'd4) begin
                    sh[10+4*d +: 4] = sh[10+4*d +: 4] + 4'd3;
                end
            end
            sh = sh << 1;
        end
        return sh[21:10];
    endfunction

    // Two-flop synchronisers on all inputs; PU gets a third flop for edge detect.
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            pu_s1   <= '0;
            pu_s2   <= '0;
            pu_s3   <= '0;
            dr_s1   <= '0;
            dr_s2   <= '0;
            mf_s1   <= '0;
            mf_s2   <= '0;
            stop_s1 <= '0;
            stop_s2 <= '0;
        end else begin
            pu_s1   <= PU;
            pu_s2   <= pu_s1;
            pu_s3   <= pu_s2;
            dr_s1   <= DR;
            dr_s2   <= dr_s1;
            mf_s1   <= MF;
            mf_s2   <= mf_s1;
            stop_s1 <= Stop;
            stop_s2 <= stop_s1;
        end
    end

    // A step counts only when the axis is energised and no Stop wins the cycle.
    assign step_evt = pu_s2 & ~pu_s3;
    assign accept   = step_evt & ~mf_s2 & ~stop_s2;

    // Position tracking with limit faults; Stop zeroes position and clears Fault.
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NAXIS; i++) begin
                pos[i] <= '0;
            end
            Fault <= '0;
            Homed <= '0;
        end else begin
            for (int i = 0; i < NAXIS; i++) begin
                if (stop_s2[i]) begin
                    pos[i]   <= '0;
                    Fault[i] <= 1'b0;
                    Homed[i] <= 1'b1;
                end else if (accept[i]) begin
                    if (dr_s2[i]) begin
                        if (pos[i] == POS_TOP) Fault[i] <= 1'b1;
                        else                   pos[i]   <= pos[i] + 10'd1;
                    end else begin
                        if (pos[i] == 10'd0) Fault[i] <= 1'b1;
                        else                 pos[i]   <= pos[i] - 10'd1;
                    end
                end
            end
        end
    end

    // Per-axis move framing: a move closes after IDLE_CYC cycles with no step.
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NAXIS; i++) begin
                state[i]      <= ST_IDLE;
                count[i]      <= '0;
                timer[i]      <= '0;
                last_steps[i] <= '0;
            end
            Moving <= '0;
            Done   <= '0;
        end else begin
            for (int i = 0; i < NAXIS; i++) begin
                Done[i] <= 1'b0;
                case (state[i])
                    ST_IDLE: begin
                        if (accept[i]) begin
                            state[i]  <= ST_MOVING;
                            Moving[i] <= 1'b1;
                            count[i]  <= 10'd1;
                            timer[i]  <= '0;
                        end
                    end
                    ST_MOVING: begin
                        if (accept[i]) begin
                            if (count[i] != CNT_TOP) count[i] <= count[i] + 10'd1;
                            timer[i] <= '0;
                        end else if (timer[i] == IDLE_LAST) begin
                            state[i]      <= ST_IDLE;
                            Moving[i]     <= 1'b0;
                            last_steps[i] <= count[i];
                            Done[i]       <= 1'b1;
                        end else begin
                            timer[i] <= timer[i] + 1'b1;
                        end
                    end
                    default: begin
                        state[i]  <= ST_IDLE;
                        Moving[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Select the readback axis; out-of-range selects read as zero.
    always_comb begin
        sel_pos  = '0;
        sel_last = '0;
        for (int i = 0; i < NAXIS; i++) begin
            if (Sel == 3'(i)) begin
                sel_pos  = pos[i];
                sel_last = last_steps[i];
            end
        end
        sel_bcd = bin2bcd(sel_pos);
    end

    // Registered readback, one cycle behind Sel or position changes.
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            PosValue0 <= '0;
            PosValue1 <= '0;
            PosValue2 <= '0;
            LastSteps <= '0;
        end else begin
            PosValue0 <= sel_bcd[11:8];
            PosValue1 <= sel_bcd[7:4];
            PosValue2 <= sel_bcd[3:0];
            LastSteps <= sel_last;
        end
    end

endmodule

// File: tb/tb_step_receiver.sv
// Bench for step_receiver: a cycle-level behavioural model of the receiver
// (positions, move lengths, idle times as plain integers) feeds an expected
// queue that is compared against the DUT every cycle, plus directed literal
// checks from the test plan and a randomised burst phase.
module tb_step_receiver;

    localparam int IDLE_CYC = 200;
    localparam int POS_MAX  = 999;
    localparam int W        = 46;

    logic       sysclk;
    logic       rst;
    logic [5:0] PU, DR, MF, Stop;
    logic [2:0] Sel;
    logic [3:0] PosValue0, PosValue1, PosValue2;
    logic [9:0] LastSteps;
    logic [5:0] Moving, Done, Homed, Fault;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    // Behavioural model state.
    int m_pos[6];
    int m_cnt[6];
    int m_last[6];
    int m_since[6];
    bit m_move[6];
    bit m_done[6];
    bit m_homed[6];
    bit m_fault[6];
    // Inputs as the receiver sees them: one, two and three cycles old.
    logic [5:0] pu_d1, pu_d2, pu_d3, dr_d1, dr_d2, mf_d1, mf_d2, st_d1, st_d2;

    // Bench-side monitors of DUT pulses.
    int done_cnt[6];
    int moving_seen[6];

    logic [5:0] act_m;
    int         burst_len;

    step_receiver dut (
        .sysclk    (sysclk),
        .rst       (rst),
        .PU        (PU),
        .DR        (DR),
        .MF        (MF),
        .Stop      (Stop),
        .Sel       (Sel),
        .PosValue0 (PosValue0),
        .PosValue1 (PosValue1),
        .PosValue2 (PosValue2),
        .LastSteps (LastSteps),
        .Moving    (Moving),
        .Done      (Done),
        .Homed     (Homed),
        .Fault     (Fault)
    );

    // Clock
    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic model_reset();
        for (int a = 0; a < 6; a++) begin
            m_pos[a] = 0; m_cnt[a] = 0; m_last[a] = 0; m_since[a] = 0;
            m_move[a] = 0; m_done[a] = 0; m_homed[a] = 0; m_fault[a] = 0;
        end
        pu_d1 = '0; pu_d2 = '0; pu_d3 = '0; dr_d1 = '0; dr_d2 = '0;
        mf_d1 = '0; mf_d2 = '0; st_d1 = '0; st_d2 = '0;
    endtask

    function automatic logic [W-1:0] pack_expect(logic [11:0] rb, logic [9:0] rl);
        logic [5:0] mv, dn, hm, ft;
        for (int a = 0; a < 6; a++) begin
            mv[a] = m_move[a]; dn[a] = m_done[a]; hm[a] = m_homed[a]; ft[a] = m_fault[a];
        end
        return {rb, rl, mv, dn, hm, ft};
    endfunction

    // Model: a step is a PU rise seen two cycles late; readback shows the
    // state from before this edge.
    task automatic model_step();
        logic [11:0] rb;
        logic [9:0]  rl;
        int          s;
        bit          step, acc;
        s = int'(Sel);
        if (s < 6) begin
            rb = {4'(m_pos[s] / 100), 4'((m_pos[s] / 10) % 10), 4'(m_pos[s] % 10)};
            rl = 10'(m_last[s]);
        end else begin
            rb = '0;
            rl = '0;
        end
        for (int a = 0; a < 6; a++) begin
            m_done[a] = 0;
            step = pu_d2[a] && !pu_d3[a];
            acc  = step && !mf_d2[a] && !st_d2[a];
            if (st_d2[a]) begin
                m_pos[a] = 0; m_fault[a] = 0; m_homed[a] = 1;
            end
            if (acc) begin
                if (dr_d2[a]) begin
                    if (m_pos[a] == POS_MAX) m_fault[a] = 1; else m_pos[a]++;
                end else begin
                    if (m_pos[a] == 0) m_fault[a] = 1; else m_pos[a]--;
                end
                if (m_move[a]) begin
                    if (m_cnt[a] < 1023) m_cnt[a]++;
                end else begin
                    m_move[a] = 1;
                    m_cnt[a]  = 1;
                end
                m_since[a] = 0;
            end else if (m_move[a]) begin
                m_since[a]++;
                if (m_since[a] == IDLE_CYC) begin
                    m_move[a] = 0;
                    m_last[a] = m_cnt[a];
                    m_done[a] = 1;
                end
            end
        end
        pu_d3 = pu_d2; pu_d2 = pu_d1; pu_d1 = PU;
        dr_d2 = dr_d1; dr_d1 = DR;
        mf_d2 = mf_d1; mf_d1 = MF;
        st_d2 = st_d1; st_d1 = Stop;
        exp_q.push_back(pack_expect(rb, rl));
    endtask

    // Asynchronous reset of the model and its pending expectations.
    always @(negedge rst) begin
        model_reset();
        exp_q.delete();
    end

    // Model advances on every rising edge.
    always @(posedge sysclk) begin
        if (!rst) begin
            model_reset();
            exp_q.push_back(pack_expect('0, '0));
        end else begin
            model_step();
        end
    end

    // Scoreboard compare and pulse monitors, 1 time unit after each edge.
    always begin
        logic [W-1:0] exp_v, act_v;
        @(posedge sysclk);
        #1;
        for (int a = 0; a < 6; a++) begin
            if (Done[a])   done_cnt[a]++;
            if (Moving[a]) moving_seen[a]++;
        end
        if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            act_v = {PosValue0, PosValue1, PosValue2, LastSteps, Moving, Done, Homed, Fault};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL outputs t=%0t actual=%h required=%h", $time, act_v, exp_v);
            end
        end
    end

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic pulses(input logic [5:0] mask, input int n, input int half);
        for (int i = 0; i < n; i++) begin
            PU = PU | mask;
            cyc(half);
            PU = PU & ~mask;
            cyc(half);
        end
    endtask

    task automatic clear_mon();
        for (int a = 0; a < 6; a++) begin
            done_cnt[a]    = 0;
            moving_seen[a] = 0;
        end
    endtask

    function automatic int pos_bcd();
        return int'({PosValue0, PosValue1, PosValue2});
    endfunction

    // Stimulus
    initial begin
        PU = '0; DR = '0; MF = '0; Stop = '0; Sel = 3'd0;
        clear_mon();
        rst = 1'b1;
        #1 rst = 1'b0;
        cyc(5);
        check_val("reset_outputs",
                  int'({PosValue0, PosValue1, PosValue2, LastSteps, Moving, Done, Homed, Fault}), 0);
        rst = 1'b1;
        cyc(3);

        // Home axis 0
        Stop[0] = 1'b1;
        cyc(200);
        Stop[0] = 1'b0;
        cyc(5);
        check_val("home0_homed", int'(Homed), 6'b000001);
        check_val("home0_pos", pos_bcd(), 12'h000);
        check_val("home0_fault", int'(Fault), 0);

        // Axis 1: 10 forward steps
        Stop[1] = 1'b1; cyc(10); Stop[1] = 1'b0;
        DR[1] = 1'b1; Sel = 3'd1;
        cyc(5);
        clear_mon();
        pulses(6'b000010, 5, 50);
        check_val("ax1_moving_mid", int'(Moving[1]), 1);
        pulses(6'b000010, 5, 50);
        check_val("ax1_moving_end", int'(Moving[1]), 1);
        cyc(300);
        check_val("ax1_moving_after", int'(Moving[1]), 0);
        check_val("ax1_done_pulses", done_cnt[1], 1);
        check_val("ax1_pos10", pos_bcd(), 12'h010);
        check_val("ax1_last10", int'(LastSteps), 10);

        // Axis 1: 7 reverse, then 5 reverse into the lower limit
        DR[1] = 1'b0;
        cyc(5);
        pulses(6'b000010, 7, 50);
        cyc(300);
        check_val("ax1_pos3", pos_bcd(), 12'h003);
        check_val("ax1_last7", int'(LastSteps), 7);
        pulses(6'b000010, 5, 50);
        cyc(300);
        check_val("ax1_pos0", pos_bcd(), 12'h000);
        check_val("ax1_fault_set", int'(Fault[1]), 1);
        check_val("ax1_last5", int'(LastSteps), 5);
        Stop[1] = 1'b1; cyc(5); Stop[1] = 1'b0; cyc(5);
        check_val("ax1_fault_clr", int'(Fault[1]), 0);

        // Axis 2: motor free, steps ignored
        MF[2] = 1'b1; DR[2] = 1'b1; Sel = 3'd2;
        cyc(5);
        clear_mon();
        pulses(6'b000100, 4, 50);
        cyc(300);
        check_val("ax2_pos_hold", pos_bcd(), 12'h000);
        check_val("ax2_no_moving", moving_seen[2], 0);
        check_val("ax2_no_done", done_cnt[2], 0);
        MF[2] = 1'b0;

        // Axis 3: Stop and step in the same synchronised cycle
        DR[3] = 1'b1; Sel = 3'd3;
        cyc(5);
        pulses(6'b001000, 5, 20);
        cyc(300);
        check_val("ax3_pos5", pos_bcd(), 12'h005);
        clear_mon();
        Stop[3] = 1'b1; PU[3] = 1'b1;
        cyc(5);
        Stop[3] = 1'b0; PU[3] = 1'b0;
        cyc(300);
        check_val("ax3_stop_pos", pos_bcd(), 12'h000);
        check_val("ax3_no_move", moving_seen[3], 0);
        check_val("ax3_last_kept", int'(LastSteps), 5);

        // Axes 0 and 4 together, reset mid-burst
        DR[0] = 1'b1; DR[4] = 1'b1; Sel = 3'd0;
        cyc(5);
        clear_mon();
        pulses(6'b010001, 2, 20);
        PU = PU | 6'b010001;
        cyc(3);
        rst = 1'b0;
        #1;
        check_val("midreset_outputs",
                  int'({PosValue0, PosValue1, PosValue2, LastSteps, Moving, Done, Homed, Fault}), 0);
        PU = '0;
        cyc(3);
        rst = 1'b1;
        cyc(300);
        check_val("midreset_no_done0", done_cnt[0], 0);
        check_val("midreset_no_done4", done_cnt[4], 0);
        cyc(5);
        pulses(6'b000001, 3, 20);
        cyc(300);
        check_val("ax0_last3", int'(LastSteps), 3);
        check_val("ax0_pos3", pos_bcd(), 12'h003);
        check_val("ax0_done", done_cnt[0], 1);

        // Axis 5: run past POS_MAX and past the count saturation point
        DR[5] = 1'b1; Sel = 3'd5;
        cyc(5);
        pulses(6'b100000, 1030, 2);
        cyc(300);
        check_val("ax5_pos999", pos_bcd(), 12'h999);
        check_val("ax5_fault", int'(Fault[5]), 1);
        check_val("ax5_last_sat", int'(LastSteps), 1023);

        // Out-of-range select
        Sel = 3'd7;
        cyc(3);
        check_val("sel7_zero", int'({PosValue0, PosValue1, PosValue2, LastSteps}), 0);

        // Randomised bursts on random axis sets
        for (int blk = 0; blk < 15; blk++) begin
            act_m     = 6'($urandom_range(1, 63));
            burst_len = $urandom_range(60, 180);
            Sel       = 3'($urandom_range(0, 7));
            for (int c = 0; c < 400; c++) begin
                @(negedge sysclk);
                for (int a = 0; a < 6; a++) begin
                    if (c < burst_len && act_m[a] && $urandom_range(0, 2) == 0) PU[a] = ~PU[a];
                    if ($urandom_range(0, 29) == 0) DR[a] = ~DR[a];
                    if ($urandom_range(0, 99) == 0) MF[a] = ~MF[a];
                    Stop[a] = ($urandom_range(0, 299) == 0);
                end
                if (c >= burst_len) PU = '0;
                if ($urandom_range(0, 19) == 0) Sel = 3'($urandom_range(0, 7));
                rst = ($urandom_range(0, 4999) == 0) ? 1'b0 : 1'b1;
            end
        end
        rst = 1'b1;
        cyc(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/step_receiver.md
Name: step_receiver

Overview:
- Six-axis step/direction receiver at the motor-driver end of the PU/DR/MF/Stop pulse interface.
- Tracks absolute position per axis from received step pulses and detects origin (Stop) sensor hits.
- Frames pulse bursts into moves and reports step count per move.
- Serves as a position-feedback block and as the self-checking end of the pulse path; per-axis position is read back as three BCD digits matching the TValue0..2 digit format.

Parameters:
- NAXIS, 6, number of axes (fixed at 6 in this design).
- IDLE_CYC, 200, sysclk cycles with no step after which a move is closed.
- POS_MAX, 999, upper position limit (BCD range 000..999).

Ports:
- sysclk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous active-low reset
- PU  input  6  step pulse per axis; rising edge = one step
- DR  input  6  direction per axis; 1 = forward (+1), 0 = reverse (-1)
- MF  input  6  motor free per axis; 1 = axis de-energised, steps ignored
- Stop  input  6  origin sensor per axis, active high
- Sel  input  3  axis select for readback (0..5)
- PosValue0  output  4  BCD hundreds digit of selected axis position
- PosValue1  output  4  BCD tens digit
- PosValue2  output  4  BCD units digit
- LastSteps  output  10  step count of last completed move, selected axis
- Moving  output  6  per-axis move in progress
- Done  output  6  per-axis one-cycle pulse at move close
- Homed  output  6  per-axis origin seen since reset
- Fault  output  6  per-axis sticky limit violation

Behaviour:
- Reset (rst=0, async): all positions, step counters, LastSteps regs and synchroniser flops = 0; Moving, Done, Homed, Fault = 0; PosValue0..2 = 0; LastSteps = 0.
- PU, DR, MF and Stop each pass through a 2-flop synchroniser; PU has a third flop for edge detect.
- Step event: sync2 PU = 1 and sync3 PU = 0.
- Position register updates on the 3rd sysclk edge after PU rises.
- DR and MF are taken from sync2 at the step event; the sender holds DR ≥ 2 cycles before each PU rise.
- Step with MF = 1: ignored. Position, counters and Moving are unchanged.
- Forward step at POS_MAX: position holds and Fault is set.
- Reverse step at 0: position holds and Fault is set.
- Fault is sticky; it clears only on reset or a Stop event.
- Stop event (sync2 Stop = 1, level): position = 0, Fault cleared, Homed set.
  - Stop has priority over a same-cycle step; that step is discarded and not counted.
  - Stop does not affect the per-axis move FSM.
- Per-axis FSM, IDLE / MOVING, with a 10-bit step counter and an idle timer:
  - IDLE, accepted step: go to MOVING, count = 1, timer = 0, Moving = 1.
  - MOVING, accepted step: count + 1, saturating at 1023; timer = 0.
  - MOVING, no step: timer + 1.
  - MOVING, timer reaches IDLE_CYC - 1: go to IDLE, Moving = 0, latch count into that axis's LastSteps register, Done = 1 for exactly one cycle.
  - A step in the same cycle as the timeout is treated as a step: stay in MOVING, no Done.
- Readback is registered, 1-cycle latency from Sel or position change:
  - Selected 10-bit position converted to BCD (double dabble) into PosValue0..2.
  - LastSteps outputs the selected axis's latched count.
  - Sel = 6 or 7: PosValue0..2 = 0 and LastSteps = 0.
- Axes are fully independent. Simultaneous steps on several axes are all counted in the same cycle.
- Reset mid-move: everything returns to reset values immediately; no Done is emitted.

Test Plan:
- Reset, then Stop[0] high 2 µs -> Homed = 6'b000001; Sel = 0 gives PosValue = 0/0/0; Fault = 0.
- Axis 1 homed, DR[1] = 1, 10 PU pulses at a 1 µs period, then quiet 3 µs -> Moving[1] high through the burst; Done[1] one-cycle pulse 200 cycles after the last step; Sel = 1 gives PosValue = 0/1/0 and LastSteps = 10.
- Then DR[1] = 0, 7 pulses -> PosValue = 0/0/3, LastSteps = 7. Then 5 more reverse pulses -> position 0, Fault[1] = 1, LastSteps = 5. Then Stop[1] -> Fault[1] = 0.
- MF[2] = 1 with 4 PU pulses on axis 2 -> position unchanged, Moving[2] never asserts, no Done[2].
- Stop[3] asserted in the same synchronised cycle as a PU[3] step from position 5 -> position 0, step not counted.
- Axes 0 and 4 stepped simultaneously, with rst pulled low mid-burst -> all outputs 0 at once, no Done. After release, a new 3-step burst gives LastSteps = 3.
